oh_fpga_link_rx: RTL and testbench

//  Receiver for the OptoHybrid FPGA 8-bit e-link, one byte per 40 MHz TTC clock.
//  - Recovers 32-bit register words sent as framed packets.
//  - Flags protocol and checksum errors.
//  - Used back-end side to decode OH read/loopback responses.
//  - Pair of link_oh_fpga_tx; frames are byte aligned upstream, so no bitslip here.

---
 rtl/oh_fpga_link_rx.sv | 109 ++++++++++
 tb/tb_oh_fpga_link_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/oh_fpga_link_rx.sv
// OptoHybrid FPGA e-link receiver: framed 32-bit words, one byte per clock.
// Define CRC8_EN to check packets with CRC-8 (0x07) instead of an XOR checksum.
module oh_fpga_link_rx #(
    parameter logic [7:0] IDLE_CHAR = 8'hBC,
    parameter logic [7:0] SOF_CHAR  = 8'h5C
) (
    input  logic        ttc_clk_40_i,
    input  logic        reset_i,
    input  logic [7:0]  elink_data_i,
    output logic        reg_data_valid_o,
    output logic [31:0] reg_data_o,
    output logic        error_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  chk_next;
    logic [31:0] reg_data_q, reg_data_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

`ifdef CRC8_EN
    // Byte-serial CRC-8, MSB first, poly 0x07, no reflection
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign chk_next = crc8_step(chk_q, elink_data_i);
`else
    assign chk_next = chk_q ^ elink_data_i;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        chk_d      = chk_q;
        reg_data_d = reg_data_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elink_data_i == SOF_CHAR) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                    chk_d   = 8'h00;
                end else if (elink_data_i != IDLE_CHAR) begin
                    error_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 3'd4) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    if (elink_data_i == chk_q) begin
                        reg_data_d = shift_q;
                        valid_d    = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else begin
                    shift_d = {shift_q[23:0], elink_data_i};
                    chk_d   = chk_next;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge ttc_clk_40_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 32'h0;
            chk_q      <= 8'h00;
            reg_data_q <= 32'h0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            chk_q      <= chk_d;
            reg_data_q <= reg_data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign reg_data_valid_o = valid_q;
    assign reg_data_o       = reg_data_q;
    assign error_o          = error_q;

endmodule

// File: tb/tb_oh_fpga_link_rx.sv
// Randomized bench for oh_fpga_link_rx against a packet-level model.
// Define CRC8_EN for both bench and design to check the CRC build.
module tb_oh_fpga_link_rx;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam logic [7:0] SOF  = 8'h5C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        valid;
    logic [31:0] data;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    bit          m_in_pkt;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_reg;
    logic        m_valid;
    logic        m_err;

    oh_fpga_link_rx dut (
        .ttc_clk_40_i     (clk),
        .reset_i          (rst_n),
        .elink_data_i     (din),
        .reg_data_valid_o (valid),
        .reg_data_o       (data),
        .error_o          (err)
    );

    always #12 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Golden checksum computed over the whole word at once
    function automatic logic [7:0] golden_chk(input logic [31:0] w);
        logic [7:0] c;
        c = 8'h00;
`ifdef CRC8_EN
        for (int i = 31; i >= 0; i--) begin
            logic fb;
            fb = c[7] ^ w[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
`else
        c = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
        return c;
    endfunction

    task automatic model_reset();
        m_in_pkt = 1'b0;
        m_bytes.delete();
        m_reg   = 32'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] b);
        logic [31:0] w;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_in_pkt) begin
            if (b == SOF) begin
                m_in_pkt = 1'b1;
                m_bytes.delete();
            end else if (b != IDLE) begin
                m_err = 1'b1;
            end
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 5) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                if (m_bytes[4] == golden_chk(w)) begin
                    m_reg   = w;
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_in_pkt = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        din = b;
        model_step(b);
        @(posedge clk);
        #1;
        check("valid", {31'h0, valid}, {31'h0, m_valid});
        check("error", {31'h0, err}, {31'h0, m_err});
        check("data", data, m_reg);
    endtask

    task automatic send_pkt(input logic [31:0] w, input logic [7:0] chk_xor);
        send_byte(SOF);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        send_byte(golden_chk(w) ^ chk_xor);
    endtask

    initial begin
        logic [31:0] w;
        int          mode;
        int          drop;

        rst_n = 1'b0;
        din   = IDLE;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_error", {31'h0, err}, 32'h0);
        check("rst_data", data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) send_byte(IDLE);

        // Explicit vectors: XOR-good and XOR-bad checksums
        send_byte(SOF); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
        send_byte(IDLE);
        send_byte(SOF); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h09);
        send_byte(IDLE);

        // Back-to-back packets, then a bad idle byte
        send_pkt(32'hDEADBEEF, 8'h00);
        send_pkt(32'h00000001, 8'h00);
        send_byte(8'h00);
        send_byte(IDLE);

        // Reset in the middle of a packet
        send_byte(SOF);
        send_byte(8'h12);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_error", {31'h0, err}, 32'h0);
        check("midrst_data", data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(32'hCAFEF00D, 8'h00);
        send_byte(IDLE);

        // Data bytes equal to SOF/IDLE are plain data
        send_pkt({SOF, IDLE, SOF, IDLE}, 8'h00);

        // Single flipped data bit must be caught
        w = 32'hA5A5_0F0F;
        send_byte(SOF);
        send_byte(w[31:24]);
        send_byte(w[23:16] ^ 8'h04);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        send_byte(golden_chk(w));

        for (int p = 0; p < 250; p++) begin
            w    = $urandom;
            mode = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) send_byte(IDLE);
            if (mode < 6) begin
                send_pkt(w, 8'h00);
            end else if (mode == 6) begin
                send_pkt(w, 8'h01 << $urandom_range(0, 7));
            end else if (mode == 7) begin
                drop = $urandom_range(1, 5);
                send_byte(SOF);
                for (int i = 1; i <= 5; i++) begin
                    if (i != drop) begin
                        if (i == 5) send_byte(golden_chk(w));
                        else send_byte(w[8*(4-i) +: 8]);
                    end
                end
            end else if (mode == 8) begin
                send_byte(8'($urandom));
            end else begin
                send_byte(SOF);
                for (int i = 0; i < 4; i++) begin
                    send_byte(w[8*(3-i) +: 8] ^ ((i == 1) ? 8'h80 : 8'h00));
                end
                send_byte(golden_chk(w));
            end
        end
        repeat (8) send_byte(IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
